// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_bus_pkg;

   // Access sequencer states: pick a master, present it to memory,
   // wait for completion, then one dead cycle before the next pick.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_t;

   // Master index assignment.
   localparam int M_CPU   = 0;
   localparam int M_VIDEO = 1;
   localparam int M_DMA   = 2;

   // Read data returned to a master whose access timed out.
   localparam logic [7:0] ERR_RDATA = 8'hFF;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the masters, the arbiter and the memory.
// Latency: none (wiring only).
// Backpressure: masters hold m_req until m_ack; memory ends an access with mem_ack.
// Master side: m_req, m_we, m_addr (master i at [i*AW +: AW]), m_wdata (packed
// by 8), m_ack (one-hot pulse), m_rdata, m_err.
// Memory side: mem_addr, mem_wr_data, mem_wr_en, mem_req, mem_ack, mem_rd_data.
// Modport slave is the arbiter's view; modport master is the environment's view.
interface mem_bus_arbiter_if #(
   parameter int N_M = 3,
   parameter int AW  = 16
);
   logic [N_M-1:0]    m_req;
   logic [N_M-1:0]    m_we;
   logic [N_M*AW-1:0] m_addr;
   logic [N_M*8-1:0]  m_wdata;
   logic [N_M-1:0]    m_ack;
   logic [7:0]        m_rdata;
   logic              m_err;
   logic [AW-1:0]     mem_addr;
   logic [7:0]        mem_wr_data;
   logic              mem_wr_en;
   logic              mem_req;
   logic              mem_ack;
   logic [7:0]        mem_rd_data;

   modport slave (
      input  m_req, m_we, m_addr, m_wdata, mem_ack, mem_rd_data,
      output m_ack, m_rdata, m_err, mem_addr, mem_wr_data, mem_wr_en, mem_req
   );

   modport master (
      output m_req, m_we, m_addr, m_wdata, mem_ack, mem_rd_data,
      input  m_ack, m_rdata, m_err, mem_addr, mem_wr_data, mem_wr_en, mem_req
   );
endinterface

// File: rtl/mem_bus_arbiter_arb_select.sv
// Winner selection: first requester strictly after ptr, searching upward with wrap.
// Latency: combinational.
// Backpressure: none; vld=0 when no request is present.
// Ports: req (request vector), ptr (last granted index), win (winner), vld.
// A constant ptr of N_M-1 turns the search into plain lowest-index-first.
module arb_select #(
   parameter int N_M = 3,
   parameter int IW  = 2
) (
   input  logic [N_M-1:0] req,
   input  logic [IW-1:0]  ptr,
   output logic [IW-1:0]  win,
   output logic           vld
);

   always_comb begin
      int idx;
      idx = 0;
      win = '0;
      vld = 1'b0;
      // Scan from the farthest offset back toward ptr+1 so the nearest
      // requester after ptr is the last (and winning) assignment.
      for (int k = N_M; k >= 1; k--) begin
         idx = (int'(ptr) + k) % N_M;
         if (req[idx]) begin
            win = IW'(idx);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates N_M masters onto a single byte-wide memory port, one access at a time.
// Latency: request seen in IDLE -> mem_req 2 cycles later; mem_ack -> m_ack next cycle.
// Backpressure: masters hold m_req until m_ack; a silent memory is aborted after TIMEOUT.
// Ports: clk, reset_n (synchronous, active-low), bus (mem_bus_arbiter_if.slave).
// Build option: define ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority
// with master 0 (CPU) highest.
module mem_bus_arbiter #(
   parameter int N_M     = 3,
   parameter int AW      = 16,
   parameter int TIMEOUT = 255
) (
   input logic              clk,
   input logic              reset_n,
   mem_bus_arbiter_if.slave bus
);
   import mem_bus_pkg::*;

   localparam int IW = (N_M > 1) ? $clog2(N_M) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_t    state, state_nxt;
   logic [IW-1:0] ptr, sel_idx, grant;
   logic          sel_vld;
   logic [AW-1:0] lat_addr;
   logic [7:0]    lat_wdata;
   logic          lat_we;
   logic [CW-1:0] cnt;
   logic          do_grant, do_issue, do_done, do_tmo;

   logic          mem_req_r, mem_wr_en_r, m_err_r;
   logic [AW-1:0] mem_addr_r;
   logic [7:0]    mem_wr_data_r, m_rdata_r;
   logic [N_M-1:0] m_ack_r;

   arb_select #(.N_M(N_M), .IW(IW)) u_sel (
      .req (bus.m_req),
      .ptr (ptr),
      .win (sel_idx),
      .vld (sel_vld)
   );

`ifdef ARB_ROUND_ROBIN_EN
   // Last granted index; the search starts just above it.
   always_ff @(posedge clk) begin
      if (!reset_n)      ptr <= IW'(N_M - 1);
      else if (do_grant) ptr <= sel_idx;
   end
`else
   // Pinning the start point to the top index yields lowest-index-first.
   assign ptr = IW'(N_M - 1);
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      do_issue  = 1'b0;
      do_done   = 1'b0;
      do_tmo    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sel_vld) begin
               do_grant  = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            do_issue  = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // A completion in the final counted cycle still beats the abort.
            if (bus.mem_ack) begin
               do_done   = 1'b1;
               state_nxt = ST_RELEASE;
            end else if (cnt == CW'(TIMEOUT)) begin
               do_tmo    = 1'b1;
               state_nxt = ST_RELEASE;
            end
         end
         // Requests are ignored here so a master still dropping its
         // request after m_ack is not served twice.
         ST_RELEASE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         grant         <= '0;
         lat_addr      <= '0;
         lat_wdata     <= '0;
         lat_we        <= 1'b0;
         cnt           <= '0;
         mem_req_r     <= 1'b0;
         mem_wr_en_r   <= 1'b0;
         mem_addr_r    <= '0;
         mem_wr_data_r <= '0;
         m_ack_r       <= '0;
         m_err_r       <= 1'b0;
         m_rdata_r     <= '0;
      end else begin
         m_ack_r <= '0;
         m_err_r <= 1'b0;
         if (do_grant) begin
            grant     <= sel_idx;
            lat_addr  <= bus.m_addr[int'(sel_idx) * AW +: AW];
            lat_wdata <= bus.m_wdata[int'(sel_idx) * 8 +: 8];
            lat_we    <= bus.m_we[sel_idx];
         end
         if (do_issue) begin
            mem_addr_r    <= lat_addr;
            mem_wr_data_r <= lat_wdata;
            mem_wr_en_r   <= lat_we;
            mem_req_r     <= 1'b1;
            cnt           <= '0;
         end
         if (state == ST_WAIT && !do_done && !do_tmo)
            cnt <= cnt + 1'b1;
         if (do_done || do_tmo) begin
            mem_req_r   <= 1'b0;
            mem_wr_en_r <= 1'b0;
            m_ack_r     <= N_M'(1) << grant;
            m_err_r     <= do_tmo;
            m_rdata_r   <= do_tmo ? ERR_RDATA : bus.mem_rd_data;
         end
      end
   end

   assign bus.mem_req     = mem_req_r;
   assign bus.mem_wr_en   = mem_wr_en_r;
   assign bus.mem_addr    = mem_addr_r;
   assign bus.mem_wr_data = mem_wr_data_r;
   assign bus.m_ack       = m_ack_r;
   assign bus.m_err       = m_err_r;
   assign bus.m_rdata     = m_rdata_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cases plus randomized traffic
// against a transaction-level model (winner choice from the arbitration rule,
// expected latencies from the documented cycle counts).
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   localparam int N_M = 3;
   localparam int AW  = 16;
   localparam int TMO = 20;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.N_M(N_M), .AW(AW)) bus ();

   mem_bus_arbiter #(.N_M(N_M), .AW(AW), .TIMEOUT(TMO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_chk = 0;
   int n_bad = 0;
   int rr_ptr = N_M - 1;   // model: last granted master

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // m_ack must never have more than one bit set.
   always @(negedge clk)
      if (reset_n === 1'b1)
         check("ack_onehot", 32'($countones(bus.m_ack) <= 1), 32'd1);

   function automatic int pick(input logic [2:0] r);
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= N_M; k++)
         if (r[(rr_ptr + k) % N_M]) return (rr_ptr + k) % N_M;
`else
      for (int i = 0; i < N_M; i++)
         if (r[i]) return i;
`endif
      return -1;
   endfunction

   // One complete access, starting with the arbiter idle.
   // delay < 0 means the memory never answers.
   task automatic run_txn(input logic [2:0] reqs, input int delay, input bit drop,
                          input bit fix, input logic [15:0] fa, input logic [7:0] fd,
                          input logic fwe, input logic [7:0] rd, output int got);
      logic [15:0] a [3];
      logic [7:0]  d [3];
      logic [2:0]  we;
      logic [2:0]  one;
      int w;
      for (int i = 0; i < N_M; i++) begin
         a[i] = 16'($urandom);
         d[i] = 8'($urandom);
      end
      we = 3'($urandom);
      w  = pick(reqs);
      if (fix) begin
         a[w]  = fa;
         d[w]  = fd;
         we[w] = fwe;
      end
      bus.m_addr  = {a[2], a[1], a[0]};
      bus.m_wdata = {d[2], d[1], d[0]};
      bus.m_we    = we;
      bus.m_req   = reqs;
      @(posedge clk); #1;                        // grant edge
      check("grant_no_mem_req", bus.mem_req, 0);
      @(posedge clk); #1;                        // issue edge
      check("issue_req", bus.mem_req, 1);
      check("issue_addr", bus.mem_addr, a[w]);
      check("issue_wen", bus.mem_wr_en, we[w]);
      check("issue_wdata", bus.mem_wr_data, d[w]);
      // Inputs move under the access; the memory side must not.
      bus.m_addr  = 48'({$urandom(), $urandom()});
      bus.m_wdata = 24'($urandom);
      if (drop) bus.m_req[w] = 1'b0;
      if (delay < 0) begin
         repeat (TMO) @(posedge clk);
         #1;
         check("tmo_hold_req", bus.mem_req, 1);
         check("tmo_hold_ack", bus.m_ack, 0);
         @(posedge clk); #1;
         check("tmo_rdata", bus.m_rdata, ERR_RDATA);
         check("tmo_err", bus.m_err, 1);
      end else begin
         repeat (delay) @(posedge clk);
         #1;
         check("wait_req", bus.mem_req, 1);
         check("wait_addr", bus.mem_addr, a[w]);
         check("wait_wdata", bus.mem_wr_data, d[w]);
         check("wait_ack", bus.m_ack, 0);
         bus.mem_ack     = 1'b1;
         bus.mem_rd_data = rd;
         @(posedge clk); #1;
         bus.mem_ack     = 1'b0;
         bus.mem_rd_data = 8'($urandom);
         check("rdata", bus.m_rdata, rd);
         check("err", bus.m_err, 0);
      end
      check("ack_vec", bus.m_ack, 32'd1 << w);
      check("req_fall", bus.mem_req, 0);
      check("wen_fall", bus.mem_wr_en, 0);
      got = -1;
      one = 3'b001;
      for (int i = 0; i < N_M; i++)
         if (bus.m_ack == (one << i)) got = i;
      rr_ptr = w;
      @(posedge clk); #1;                        // release edge, request still high
      check("release_ack", bus.m_ack, 0);
      check("release_req", bus.mem_req, 0);
      bus.m_req[w] = 1'b0;
   endtask

   // Quiet cycles with a stray mem_ack that must be ignored.
   task automatic idle_gap(input int n);
      bus.m_req = '0;
      for (int i = 0; i < n; i++) begin
         bus.mem_ack     = (i == 1);
         bus.mem_rd_data = 8'h5C;
         @(posedge clk); #1;
         check("idle_req", bus.mem_req, 0);
         check("idle_ack", bus.m_ack, 0);
      end
      bus.mem_ack = 1'b0;
   endtask

   int g;
   int exp_ord [4];
   logic [2:0] r;
   int dly;

   initial begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_ord = '{0, 1, 2, 0};
`else
      exp_ord = '{0, 0, 0, 0};
`endif
      reset_n         = 1'b0;
      bus.m_req       = '0;
      bus.m_we        = '0;
      bus.m_addr      = '0;
      bus.m_wdata     = '0;
      bus.mem_ack     = 1'b0;
      bus.mem_rd_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_wen", bus.mem_wr_en, 0);
      check("rst_ack", bus.m_ack, 0);
      check("rst_err", bus.m_err, 0);
      check("rst_rdata", bus.m_rdata, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_wdata", bus.mem_wr_data, 0);
      reset_n = 1'b1;
      rr_ptr  = N_M - 1;

      // All three request together and keep requesting.
      for (int i = 0; i < 4; i++) begin
         run_txn(3'b111, 1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 8'($urandom), g);
         check("order", g, exp_ord[i]);
      end
      idle_gap(3);

      // CPU read, memory answers 3 cycles after mem_req.
      run_txn(3'b001, 3, 1'b0, 1'b1, 16'h0444, 8'h00, 1'b0, 8'hA9, g);
      check("cpu_read_who", g, M_CPU);
      idle_gap(2);

      // DMA write.
      run_txn(3'b100, 2, 1'b0, 1'b1, 16'h2000, 8'h5A, 1'b1, 8'h00, g);
      check("dma_write_who", g, M_DMA);
      idle_gap(2);

      // Video access with a silent memory; request held past its ack.
      run_txn(3'b010, -1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 8'h00, g);
      check("tmo_who", g, M_VIDEO);
      idle_gap(4);

      // Randomized traffic.
      for (int t = 0; t < 60; t++) begin
         r   = 3'($urandom_range(1, 7));
         dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
         run_txn(r, dly, $urandom_range(0, 3) == 0, 1'b0, 16'h0, 8'h0, 1'b0,
                 8'($urandom), g);
         if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
      end
      idle_gap(2);

      // Reset in the middle of a wait, followed by a late mem_ack.
      bus.m_req = 3'b010;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_req", bus.mem_req, 1);
      @(posedge clk); #1;
      reset_n   = 1'b0;
      bus.m_req = '0;
      @(posedge clk); #1;
      check("midrst_req", bus.mem_req, 0);
      check("midrst_ack", bus.m_ack, 0);
      reset_n         = 1'b1;
      rr_ptr          = N_M - 1;
      bus.mem_ack     = 1'b1;
      bus.mem_rd_data = 8'h33;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("late_ack", bus.m_ack, 0);
         check("late_req", bus.mem_req, 0);
         check("late_rdata", bus.m_rdata, 0);
         @(posedge clk); #1;
      end

      // Selection after reset starts from master 0 again.
      run_txn(3'b111, 0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 8'($urandom), g);
      check("post_rst_who", g, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
